// File: rtl/hazard_fwd_ctrl_pkg.sv
// hazard_fwd_ctrl_pkg: shared constants for the hazard/forwarding controller.
//   FWD_*      forwarding-mux select codes (6..15 unused)
//   SRC_*      result-source encoding carried through the shadow pipeline
//   TUSE_NONE  Tuse value meaning "operand not read"
//   TNEW_*     default Tnew for each result source
package hazard_fwd_ctrl_pkg;

    localparam int FWD_NONE  = 0;
    localparam int FWD_M_ALU = 1;
    localparam int FWD_M_PC  = 2;
    localparam int FWD_W_ALU = 3;
    localparam int FWD_W_DM  = 4;
    localparam int FWD_W_PC  = 5;

    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_DM  = 2'd1;
    localparam logic [1:0] SRC_PC  = 2'd2;

    localparam int TUSE_NONE = 3;

    localparam int TNEW_ALU = 1;
    localparam int TNEW_DM  = 2;
    localparam int TNEW_PC  = 1;

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// hazard_fwd_ctrl_if: bundle between the decode/datapath side and the
// hazard/forwarding controller.
//   master: drives D-stage decode (rs/rt, Tuse, dst, Tnew, src), reads
//           stall, the five forwarding selects and stall_cnt.
//   slave : the controller, mirror image of master.
interface hazard_fwd_ctrl_if #(
    parameter int RAW  = 5,
    parameter int TW   = 2,
    parameter int SELW = 4
);
    logic [RAW-1:0]  rs_D;
    logic [RAW-1:0]  rt_D;
    logic [TW-1:0]   tuse_rs_D;
    logic [TW-1:0]   tuse_rt_D;
    logic [RAW-1:0]  dst_D;
    logic [TW-1:0]   tnew_D;
    logic [1:0]      src_D;

    logic            stall;
    logic [SELW-1:0] sel_cmp1_D;
    logic [SELW-1:0] sel_cmp2_D;
    logic [SELW-1:0] sel_alua_E;
    logic [SELW-1:0] sel_alub_E;
    logic [SELW-1:0] sel_dm_M;
    logic [31:0]     stall_cnt;

    modport master (
        output rs_D, rt_D, tuse_rs_D, tuse_rt_D, dst_D, tnew_D, src_D,
        input  stall, sel_cmp1_D, sel_cmp2_D, sel_alua_E, sel_alub_E,
               sel_dm_M, stall_cnt
    );

    modport slave (
        input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, dst_D, tnew_D, src_D,
        output stall, sel_cmp1_D, sel_cmp2_D, sel_alua_E, sel_alub_E,
               sel_dm_M, stall_cnt
    );
endinterface

// File: rtl/hazard_fwd_ctrl_fwd_sel_unit.sv
// fwd_sel_unit: combinational forwarding select for one operand.
//   r          operand register number
//   dst_m/tnew_m/src_m  M-stage writer metadata
//   dst_w/src_w         W-stage writer metadata
//   en_m       allow M-stage forwarding (0 for the M-stage consumer itself)
//   sel        FWD_* select code
// M is younger than W, so a ready M result wins over W.
module fwd_sel_unit
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int RAW  = 5,
    parameter int TW   = 2,
    parameter int SELW = 4
) (
    input  logic [RAW-1:0]  r,
    input  logic [RAW-1:0]  dst_m,
    input  logic [TW-1:0]   tnew_m,
    input  logic [1:0]      src_m,
    input  logic [RAW-1:0]  dst_w,
    input  logic [1:0]      src_w,
    input  logic            en_m,
    output logic [SELW-1:0] sel
);
    logic m_hit;
    logic w_hit;

    assign m_hit = en_m && (dst_m != '0) && (dst_m == r) && (tnew_m == '0);
    assign w_hit = (dst_w != '0) && (dst_w == r);

    always_comb begin
        sel = SELW'(FWD_NONE);
        if (m_hit) begin
            // A DM result is never ready in M; only ALU and PC-link forward.
            if (src_m == SRC_ALU)     sel = SELW'(FWD_M_ALU);
            else if (src_m == SRC_PC) sel = SELW'(FWD_M_PC);
        end else if (w_hit) begin
            case (src_w)
                SRC_ALU: sel = SELW'(FWD_W_ALU);
                SRC_DM:  sel = SELW'(FWD_W_DM);
                SRC_PC:  sel = SELW'(FWD_W_PC);
                default: sel = SELW'(FWD_NONE);
            endcase
        end
    end
endmodule

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: stall and forwarding control for the 5-stage pipeline.
//   clk, reset  clock and synchronous active-high reset
//   bus (slave) D-stage decode in; stall, forwarding selects, stall_cnt out
// Keeps shadow E/M/W metadata ({rs, rt, dst, tnew, src}) and derives the
// D/E/M forwarding selects and the D stall from it.
// Optional: HAZ_STALL_CNT_EN adds a saturating stall-cycle counter;
// otherwise stall_cnt is tied to zero.
module hazard_fwd_ctrl
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int RAW  = 5,
    parameter int TW   = 2,
    parameter int SELW = 4
) (
    input  logic             clk,
    input  logic             reset,
    hazard_fwd_ctrl_if.slave bus
);
    localparam int NSEL = 5;

    typedef struct packed {
        logic [RAW-1:0] rs;
        logic [RAW-1:0] rt;
        logic [RAW-1:0] dst;
        logic [TW-1:0]  tnew;
        logic [1:0]     src;
    } stage_t;

    stage_t e_q, e_d;
    stage_t m_q, m_d;
    stage_t w_q, w_d;
    logic   stall;

    // Operand r causes a stall if a writer in E or M will not have its
    // result in a forwardable register by the time r is consumed.
    function automatic logic op_haz(input logic [RAW-1:0] r,
                                    input logic [TW-1:0]  tuse,
                                    input stage_t         e,
                                    input stage_t         m);
        logic e_hit;
        logic m_hit;
        e_hit = (e.dst != '0) && (e.dst == r) && (e.tnew > tuse);
        m_hit = (m.dst != '0) && (m.dst == r) && (m.tnew > tuse);
        return (tuse != TW'(TUSE_NONE)) && (e_hit || m_hit);
    endfunction

    always_comb begin
        stall = op_haz(bus.rs_D, bus.tuse_rs_D, e_q, m_q) ||
                op_haz(bus.rt_D, bus.tuse_rt_D, e_q, m_q);
    end

    always_comb begin
        e_d = '0;
        if (!stall) begin
            e_d.rs   = bus.rs_D;
            e_d.rt   = bus.rt_D;
            e_d.dst  = bus.dst_D;
            e_d.tnew = bus.tnew_D;
            e_d.src  = bus.src_D;
        end
        m_d      = e_q;
        m_d.tnew = (e_q.tnew == '0) ? '0 : e_q.tnew - 1'b1;
        w_d      = m_q;
        w_d.tnew = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

    // Selector index: 0 cmp1_D, 1 cmp2_D, 2 alua_E, 3 alub_E, 4 dm_M.
    logic [NSEL-1:0][RAW-1:0]  op_r;
    logic [NSEL-1:0]           en_m;
    logic [NSEL-1:0][SELW-1:0] sel;

    assign op_r = {m_q.rt, e_q.rt, e_q.rs, bus.rt_D, bus.rs_D};
    // Store data in M can only take W; M cannot forward to itself.
    assign en_m = 5'b01111;

    for (genvar i = 0; i < NSEL; i++) begin : g_sel
        fwd_sel_unit #(
            .RAW  (RAW),
            .TW   (TW),
            .SELW (SELW)
        ) u_sel (
            .r      (op_r[i]),
            .dst_m  (m_q.dst),
            .tnew_m (m_q.tnew),
            .src_m  (m_q.src),
            .dst_w  (w_q.dst),
            .src_w  (w_q.src),
            .en_m   (en_m[i]),
            .sel    (sel[i])
        );
    end

    assign bus.stall      = stall;
    assign bus.sel_cmp1_D = sel[0];
    assign bus.sel_cmp2_D = sel[1];
    assign bus.sel_alua_E = sel[2];
    assign bus.sel_alub_E = sel[3];
    assign bus.sel_dm_M   = sel[4];

`ifdef HAZ_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign bus.stall_cnt = stall_cnt_q;
`else
    assign bus.stall_cnt = '0;
`endif

    // Fields kept for a complete stage record but never consulted here.
    logic unused_fields;
    assign unused_fields = ^{m_q.rs, w_q.rs, w_q.rt, w_q.tnew};

endmodule
